// File: rtl/ir_direction_queue.sv
// rtl/ir_direction_queue.sv - NEC word stabiliser, validator and direction turn queue for the snake core
// Optional macro IR_STRICT_ADDR_EN: also require the frame address to equal NEC_ADDR.
module ir_direction_queue #(
   parameter int         STABLE_CYCLES = 16,
   parameter int         QDEPTH        = 2,
   parameter logic [7:0] NEC_ADDR      = 8'h00,
   parameter logic [7:0] CODE_UP       = 8'h18,
   parameter logic [7:0] CODE_RIGHT    = 8'h5A,
   parameter logic [7:0] CODE_DOWN     = 8'h52,
   parameter logic [7:0] CODE_LEFT     = 8'h08
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] word,
   input  logic        game_tick,
   output logic [1:0]  direction,
   output logic        dir_changed,
   output logic [2:0]  queue_level,
   output logic [7:0]  frame_err_cnt
);

   typedef enum logic {IDLE, CHECK} state_t;

   state_t      state_q;
   logic [31:0] word_q;
   logic [31:0] last_word_q;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  dir_q, dir_d;
   logic        dir_changed_q;
   logic [2:0]  level_q, level_d;
   logic [7:0]  err_q;
   logic [1:0]  q_q [QDEPTH];
   logic [1:0]  q_d [QDEPTH];

   logic       capture, frame_ok, addr_ok, code_hit, pop, push;
   logic [1:0] cand, tail;

   // The captured frame lives in last_word_q, so CHECK is immune to the input moving on.
`ifdef IR_STRICT_ADDR_EN
   assign addr_ok = (last_word_q[7:0] == NEC_ADDR);
`else
   logic unused_addr;
   assign unused_addr = ^NEC_ADDR;
   assign addr_ok     = 1'b1;
`endif

   assign frame_ok = (last_word_q[15:8] == ~last_word_q[7:0]) &&
                     (last_word_q[31:24] == ~last_word_q[23:16]) && addr_ok;
   assign capture  = (state_q == IDLE) && (cnt_q == 8'(STABLE_CYCLES - 1)) &&
                     (word_q != last_word_q);

   always_comb begin
      code_hit = 1'b1;
      cand     = 2'b00;
      case (last_word_q[23:16])
         CODE_UP:    cand = 2'b00;
         CODE_RIGHT: cand = 2'b01;
         CODE_DOWN:  cand = 2'b10;
         CODE_LEFT:  cand = 2'b11;
         default:    code_hit = 1'b0;
      endcase
   end

   always_comb begin
      cnt_d = 8'd0;
      if (word == word_q)
         cnt_d = (cnt_q == 8'(STABLE_CYCLES - 1)) ? cnt_q : cnt_q + 8'd1;
   end

   always_comb begin
      tail = dir_q;
      for (int i = 0; i < QDEPTH; i++)
         if (3'(i + 1) == level_q) tail = q_q[i];

      pop  = game_tick && (level_q != 3'd0);
      push = (state_q == CHECK) && frame_ok && code_hit &&
             (cand != tail) && (cand != {~tail[1], tail[0]}) &&
             ((level_q < 3'(QDEPTH)) || pop);

      q_d     = q_q;
      level_d = level_q;
      dir_d   = dir_q;
      if (pop) begin
         dir_d = q_q[0];
         for (int i = 0; i < QDEPTH - 1; i++) q_d[i] = q_q[i + 1];
         level_d = level_q - 3'd1;
      end
      if (push) begin
         for (int i = 0; i < QDEPTH; i++)
            if (3'(i) == level_d) q_d[i] = cand;
         level_d = level_d + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         word_q        <= 32'd0;
         last_word_q   <= 32'd0;
         cnt_q         <= 8'd0;
         dir_q         <= 2'b01;
         dir_changed_q <= 1'b0;
         level_q       <= 3'd0;
         err_q         <= 8'd0;
         for (int i = 0; i < QDEPTH; i++) q_q[i] <= 2'b00;
      end else begin
         word_q        <= word;
         cnt_q         <= cnt_d;
         dir_q         <= dir_d;
         dir_changed_q <= pop;
         level_q       <= level_d;
         q_q           <= q_d;
         case (state_q)
            IDLE: begin
               if (capture) begin
                  last_word_q <= word_q;
                  state_q     <= CHECK;
               end
            end
            CHECK: begin
               state_q <= IDLE;
               if (!frame_ok && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign direction     = dir_q;
   assign dir_changed   = dir_changed_q;
   assign queue_level   = level_q;
   assign frame_err_cnt = err_q;

endmodule
